// File: rtl/odd_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : odd_sched_pkg
//  Description : Shared types and constants for the odd-counter scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package odd_sched_pkg;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam int ODD_SCHED_MAX_REQ  = 4;
    localparam int ODD_SCHED_CNT_STEP = 2;

    // Requester index / pointer width, sized for the largest supported N_REQ
    localparam int ODD_SCHED_IDX_W = $clog2(ODD_SCHED_MAX_REQ);

    // Round-robin pointer advance: index after the winner, wrapping at n_req
    function automatic logic [ODD_SCHED_IDX_W-1:0] next_ptr(
        input logic [ODD_SCHED_IDX_W-1:0] idx,
        input int                         n_req
    );
        return (int'(idx) == n_req - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/odd_sched_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : odd_sched_rr_arb
//  Description : Combinational round-robin picker. Chooses the first active
//                request at or after the pointer, wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
module odd_sched_rr_arb
    import odd_sched_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]           req,
    input  logic [ODD_SCHED_IDX_W-1:0] ptr,
    output logic [N_REQ-1:0]           pick,
    output logic [ODD_SCHED_IDX_W-1:0] idx
);

    logic w_found;

    // Two passes: indices from the pointer upward, then the wrapped-around low indices
    always_comb begin
        pick    = '0;
        idx     = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req[i] && (i >= int'(ptr))) begin
                w_found = 1'b1;
                pick[i] = 1'b1;
                idx     = ODD_SCHED_IDX_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req[i] && (i < int'(ptr))) begin
                w_found = 1'b1;
                pick[i] = 1'b1;
                idx     = ODD_SCHED_IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/odd_counter_sched.sv
`default_nettype none
// ============================================================================
//  Module      : odd_counter_sched
//  Description : Shares one odd-number counter (1, 3, 5, ...) between N_REQ
//                requesters. A round-robin arbiter grants one run at a time;
//                the run counts up to the granted (odd-rounded) limit, then
//                pulses done. Dropping the granted request aborts the run.
//  Options     : ODD_SCHED_PAUSE_EN - adds input 'pause', which freezes a
//                running count (abort still takes priority).
//  Revision    : 1.0 - initial release
// ============================================================================
module odd_counter_sched
    import odd_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef ODD_SCHED_PAUSE_EN
    input  logic                     pause,
`endif
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_limit,
    output logic [N_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]         od_counter,
    output logic                     busy,
    output logic                     done
);

    localparam logic [WIDTH-1:0] c_cnt_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_cnt_step = WIDTH'(ODD_SCHED_CNT_STEP);

    generate
        if ((N_REQ < 2) || (N_REQ > ODD_SCHED_MAX_REQ)) begin : g_bad_n_req
            $error("odd_counter_sched: N_REQ must be in 2..4");
        end
    endgenerate

    sched_state_t                 r_state;
    sched_state_t                 w_state_nxt;
    logic [WIDTH-1:0]             r_cnt;
    logic [WIDTH-1:0]             w_cnt_nxt;
    logic [WIDTH-1:0]             r_limit;
    logic [WIDTH-1:0]             w_limit_nxt;
    logic [WIDTH-1:0]             w_lim_sel;
    logic [N_REQ-1:0]             r_gnt;
    logic [N_REQ-1:0]             w_gnt_nxt;
    logic [N_REQ-1:0]             w_pick;
    logic [ODD_SCHED_IDX_W-1:0]   r_ptr;
    logic [ODD_SCHED_IDX_W-1:0]   w_ptr_nxt;
    logic [ODD_SCHED_IDX_W-1:0]   w_pick_idx;
    logic                         w_own_req;
    logic                         w_pause;

`ifdef ODD_SCHED_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    odd_sched_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req  (req),
        .ptr  (r_ptr),
        .pick (w_pick),
        .idx  (w_pick_idx)
    );

    // The granted requester still holds its request (abort detection)
    assign w_own_req = |(req & r_gnt);

    // Limit of the requester the arbiter would pick this cycle
    always_comb begin
        w_lim_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
                w_lim_sel = req_limit[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and next-datapath decode; everything holds unless changed below
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_limit_nxt = r_limit;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = c_cnt_one;
                if (|req) begin
                    // OR with 1 rounds even limits up and maps 0 to 1
                    w_limit_nxt = w_lim_sel | c_cnt_one;
                    w_gnt_nxt   = w_pick;
                    w_ptr_nxt   = next_ptr(w_pick_idx, N_REQ);
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!w_own_req) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = c_cnt_one;
                    w_gnt_nxt   = '0;
                end else if (w_pause) begin
                    w_state_nxt = RUN;
                end else if (r_cnt == r_limit) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_step;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = c_cnt_one;
                w_gnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = c_cnt_one;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State, counter, grant, latched limit and round-robin pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= c_cnt_one;
            r_gnt   <= '0;
            r_limit <= c_cnt_one;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_limit <= w_limit_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign gnt        = r_gnt;
    assign od_counter = r_cnt;
    assign busy       = (r_state == RUN) || (r_state == DONE);
    assign done       = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_odd_counter_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_odd_counter_sched
//  Description : Scoreboard bench for odd_counter_sched. Stimulus pushes the
//                expected outcome of every run (winner, final count, how it
//                ends); a negedge monitor reconstructs each run from the DUT
//                outputs and compares it. Build with +define+ODD_SCHED_PAUSE_EN
//                to include the pause scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_odd_counter_sched;

    localparam int N_REQ = 2;
    localparam int WIDTH = 8;

    logic                     clk       = 1'b0;
    logic                     reset     = 1'b1;
    logic                     pause     = 1'b0;
    logic [N_REQ-1:0]         req       = '0;
    logic [N_REQ*WIDTH-1:0]   req_limit = '0;
    logic [N_REQ-1:0]         gnt;
    logic [WIDTH-1:0]         od_counter;
    logic                     busy;
    logic                     done;

    always #5 clk = ~clk;

    odd_counter_sched #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef ODD_SCHED_PAUSE_EN
        .pause      (pause),
`endif
        .req        (req),
        .req_limit  (req_limit),
        .gnt        (gnt),
        .od_counter (od_counter),
        .busy       (busy),
        .done       (done)
    );

    // One expected run outcome
    typedef struct {
        bit               abort;
        logic [N_REQ-1:0] gnt;
        int               last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   mptr     = 0;
    int   lim[N_REQ];

    function automatic void check(input bit ok, input string name, input int act, input int req_val);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req_val);
    endfunction

    // Reference arbitration: first active requester at or after the pointer
    function automatic int model_pick(input logic [N_REQ-1:0] m);
        for (int k = 0; k < N_REQ; k++) begin
            int c;
            c = (mptr + k) % N_REQ;
            if (m[c]) return c;
        end
        return 0;
    endfunction

    function automatic void push_exp(input bit ab, input int w, input int last);
        exp_t e;
        e.abort = ab;
        e.gnt   = N_REQ'(1 << w);
        e.last  = last;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_limits();
        for (int i = 0; i < N_REQ; i++) req_limit[i*WIDTH +: WIDTH] = WIDTH'(lim[i]);
    endtask

    task automatic wait_count(input int v, input string name);
        int cyc;
        cyc = 0;
        while (!(busy && !done && int'(od_counter) == v) && cyc < 400) begin
            tick();
            cyc++;
        end
        if (cyc >= 400) check(1'b0, name, int'(od_counter), v);
    endtask

    // Hold 'mask' until nruns completions have been seen, then release
    task automatic run_job(input logic [N_REQ-1:0] mask, input int nruns, input bit scramble);
        int w, seen, cyc;
        for (int r = 0; r < nruns; r++) begin
            w = model_pick(mask);
            push_exp(1'b0, w, lim[w] | 1);
            mptr = (w + 1) % N_REQ;
        end
        apply_limits();
        req  = mask;
        seen = 0;
        cyc  = 0;
        while (seen < nruns && cyc < nruns * 300) begin
            tick();
            cyc++;
            if (done) seen++;
            if (scramble && cyc == 2) req_limit = N_REQ*WIDTH'($urandom);
        end
        if (seen < nruns) begin
            check(1'b0, "job_timeout", seen, nruns);
            exp_q.delete();
        end
        req = '0;
        tick();
        tick();
    endtask

    // Monitor: rebuild each run from the outputs and score it against the queue
    bit               in_run     = 1'b0;
    bit               seq_ok     = 1'b0;
    bit               prev_pause = 1'b0;
    int               run_len    = 0;
    int               hold       = 0;
    int               prev_cnt   = 0;
    logic [N_REQ-1:0] run_gnt    = '0;

    always @(negedge clk) begin
        exp_t e;
        if (busy && !done) begin
            if (!in_run) begin
                in_run  = 1'b1;
                run_len = 0;
                hold    = 0;
                run_gnt = gnt;
                seq_ok  = (od_counter == 1) && ($countones(gnt) == 1);
            end else begin
                if (int'(od_counter) == prev_cnt && prev_pause) hold++;
                else if (int'(od_counter) != prev_cnt + 2) seq_ok = 1'b0;
                if (gnt != run_gnt) seq_ok = 1'b0;
            end
            run_len++;
            prev_cnt   = int'(od_counter);
            prev_pause = pause;
        end else if (done) begin
            if (!in_run) begin
                check(1'b0, "done_without_run", 1, 0);
            end else if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check(!e.abort, "end_kind_done", 0, int'(e.abort));
                check(gnt == e.gnt, "done_gnt", int'(gnt), int'(e.gnt));
                check(int'(od_counter) == e.last, "done_count", int'(od_counter), e.last);
                check(run_len - hold == (e.last + 1) / 2, "run_length", run_len - hold, (e.last + 1) / 2);
                check(seq_ok, "odd_sequence", int'(seq_ok), 1);
            end
            in_run = 1'b0;
        end else begin
            if (in_run) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_abort", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(e.abort, "end_kind_abort", 1, int'(e.abort));
                    check(run_gnt == e.gnt, "abort_gnt", int'(run_gnt), int'(e.gnt));
                    check(prev_cnt == e.last, "abort_count", prev_cnt, e.last);
                    check(seq_ok, "abort_sequence", int'(seq_ok), 1);
                end
                in_run = 1'b0;
            end
            check(gnt == '0 && od_counter == 1, "idle_outputs", int'(od_counter), 1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        logic [N_REQ-1:0] mask;
        int nruns;
        for (int i = 0; i < N_REQ; i++) lim[i] = 0;

        // Reset values
        #13;
        check(gnt == '0 && od_counter == 1 && !busy && !done, "reset_values", int'(od_counter), 1);
        tick();
        reset = 1'b0;
        tick();

        // Single requester, limit 7
        lim[0] = 7;
        run_job(2'b01, 1, 1'b0);
        // Even limit rounds up, zero limit is a one-cycle run
        lim[0] = 6;
        run_job(2'b01, 1, 1'b0);
        lim[0] = 0;
        run_job(2'b01, 1, 1'b0);

        // Abort at count 5 of a limit-9 run
        lim[0] = 9;
        apply_limits();
        w = model_pick(2'b01);
        push_exp(1'b1, w, 5);
        mptr = (w + 1) % N_REQ;
        req = 2'b01;
        wait_count(5, "abort_wait");
        req = '0;
        tick();
        check(!busy && !done && od_counter == 1, "abort_to_idle", int'(busy), 0);
        tick();

        // Asynchronous reset mid-run at count 11
        lim[0] = 21;
        apply_limits();
        w = model_pick(2'b01);
        push_exp(1'b1, w, 11);
        req = 2'b01;
        wait_count(11, "reset_wait");
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check(gnt == '0, "async_reset_gnt", int'(gnt), 0);
        check(od_counter == 1, "async_reset_count", int'(od_counter), 1);
        check(!busy && !done, "async_reset_busy", int'(busy), 0);
        mptr = 0;
        req  = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Contention from a fresh pointer: grants 01, 10, 01
        lim[0] = 3;
        lim[1] = 5;
        run_job(2'b11, 3, 1'b0);

        // Maximum limit: must end at 255 without wrapping
        lim[0] = 255;
        run_job(2'b01, 1, 1'b0);

`ifdef ODD_SCHED_PAUSE_EN
        // Pause for three cycles at count 3
        lim[0] = 11;
        apply_limits();
        w = model_pick(2'b01);
        push_exp(1'b0, w, 11);
        mptr = (w + 1) % N_REQ;
        req = 2'b01;
        wait_count(3, "pause_wait");
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check(od_counter == 3 && busy, "pause_hold", int'(od_counter), 3);
        end
        pause = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (!done && cyc < 100) begin
                tick();
                cyc++;
            end
            if (!done) check(1'b0, "pause_resume_timeout", 0, 1);
        end
        req = '0;
        tick();
        tick();
`endif

        // Randomized jobs
        for (int it = 0; it < 12; it++) begin
            mask  = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            nruns = $urandom_range(1, 3);
            for (int i = 0; i < N_REQ; i++) begin
                lim[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 24);
            end
            run_job(mask, nruns, nruns == 1);
        end

        tick();
        tick();
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
